// File: rtl/mem_ctrl.sv
// Line-burst memory controller: reads wait LATENCY cycles then stream BLOCKSIZE bytes; writes capture BLOCKSIZE bytes then commit after LATENCY.
// Latency 4+LATENCY... per burst; backpressure: ready_mem low for the whole transaction, requests outside IDLE are ignored.
module mem_ctrl #(
    parameter int AWIDTH    = 16,
    parameter int DWIDTH    = 8,
    parameter int BLOCKSIZE = 4,
    parameter int MADDR     = 10,
    parameter int LATENCY   = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] addr_mem,
    inout  logic [DWIDTH-1:0] data_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    output logic              ready_mem,
    output logic              rvalid_mem
);
    localparam int BW = $clog2(BLOCKSIZE);
    localparam logic [BW-1:0] LAST_IDX = BW'(BLOCKSIZE - 1);
    localparam logic [3:0]    LAT_M1   = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BURST, WR_CAPTURE, WR_COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_ready;
    logic [MADDR-BW-1:0] r_line;
    logic [BW-1:0]       r_idx;
    logic [3:0]          r_cnt;
    logic [DWIDTH-1:0]   r_buf [BLOCKSIZE];
    logic [DWIDTH-1:0]   r_mem [2**MADDR];
    logic                w_accept;
    logic                w_commit;
    logic                w_drive;
    logic [DWIDTH-1:0]   w_rdata;
    logic                w_unused;

    assign w_accept = (r_state == IDLE) && r_ready && (rd_mem || wr_mem);
    assign w_commit = (r_state == WR_COMMIT) && (r_cnt == 4'd0);
    assign w_unused = ^addr_mem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_accept) w_next = rd_mem ? RD_WAIT : WR_CAPTURE;
            RD_WAIT:    if (r_cnt == 4'd0) w_next = RD_BURST;
            RD_BURST:   if (r_idx == LAST_IDX) w_next = IDLE;
            WR_CAPTURE: if (r_idx == LAST_IDX) w_next = WR_COMMIT;
            WR_COMMIT:  if (r_cnt == 4'd0) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        rvalid_mem = (r_state == RD_BURST);
        w_drive    = (r_state == RD_BURST);
        ready_mem  = r_ready;
    end

    // Byte address is {line, index}: a burst can never carry into the next line.
    assign w_rdata  = r_mem[{r_line, r_idx}];
    assign data_mem = w_drive ? w_rdata : 'z;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_line  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            for (int k = 0; k < BLOCKSIZE; k++) r_buf[k] <= '0;
        end else begin
            r_ready <= (w_next == IDLE);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_line <= addr_mem[MADDR-1:BW];
                    r_cnt  <= LAT_M1;
                    r_idx  <= '0;
                end
                RD_WAIT:    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                RD_BURST:   r_idx <= r_idx + 1'b1;
                WR_CAPTURE: begin
                    r_buf[r_idx] <= data_mem;
                    r_idx        <= r_idx + 1'b1;
                end
                WR_COMMIT:  if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately outside reset so contents survive an abort.
    always_ff @(posedge clock) begin
        if (reset_n && w_commit) begin
            for (int k = 0; k < BLOCKSIZE; k++) r_mem[{r_line, BW'(k)}] <= r_buf[k];
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three builds (LATENCY 4, 1, 15) selected by sel; scoreboard queue of expected read bytes.
module tb_mem_ctrl;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        rd, wr;
    logic        tb_drv;
    logic [7:0]  tb_dat;
    int          sel;
    wire  [7:0]  d0, d1, d2;
    logic        rdy0, rdy1, rdy2, rv0, rv1, rv2;

    logic [7:0]  mdl [3][1024];
    logic [7:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    assign d0 = tb_drv ? tb_dat : 8'bz;
    assign d1 = tb_drv ? tb_dat : 8'bz;
    assign d2 = tb_drv ? tb_dat : 8'bz;

    mem_ctrl #(.LATENCY(4)) u0 (.clock(clock), .reset_n(reset_n), .addr_mem(addr), .data_mem(d0),
        .rd_mem(rd && sel == 0), .wr_mem(wr && sel == 0), .ready_mem(rdy0), .rvalid_mem(rv0));
    mem_ctrl #(.LATENCY(1)) u1 (.clock(clock), .reset_n(reset_n), .addr_mem(addr), .data_mem(d1),
        .rd_mem(rd && sel == 1), .wr_mem(wr && sel == 1), .ready_mem(rdy1), .rvalid_mem(rv1));
    mem_ctrl #(.LATENCY(15)) u2 (.clock(clock), .reset_n(reset_n), .addr_mem(addr), .data_mem(d2),
        .rd_mem(rd && sel == 2), .wr_mem(wr && sel == 2), .ready_mem(rdy2), .rvalid_mem(rv2));

    wire       rdy_m = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    wire       rv_m  = (sel == 0) ? rv0  : (sel == 1) ? rv1  : rv2;
    wire [7:0] d_m   = (sel == 0) ? d0   : (sel == 1) ? d1   : d2;

    function automatic int lat_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 1 : 15;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] b [4], input bit abort);
        int low;
        logic [1:0] kk;
        low = 0;
        @(negedge clock);
        n_cmp++;
        if (rdy_m !== 1'b1) begin n_bad++; $display("FAIL wr_ready_pre: got %b want 1", rdy_m); end
        addr = a; wr = 1'b1;
        @(posedge clock); #1 wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tb_drv = 1'b1; tb_dat = b[k];
            @(negedge clock);
            if (!rdy_m) low++;
            @(posedge clock); #1;
        end
        tb_drv = 1'b0;
        if (abort) begin
            @(negedge clock);
            @(posedge clock); #1 reset_n = 1'b0;
            #1;
            n_cmp++;
            if (rdy_m !== 1'b1 || rv_m !== 1'b0) begin
                n_bad++; $display("FAIL abort_ready: ready=%b rvalid=%b want 1/0", rdy_m, rv_m);
            end
            #2 reset_n = 1'b1;
            return;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (rdy_m) break;
            low++;
            @(posedge clock);
        end
        n_cmp++;
        if (low != 4 + lat_of(sel)) begin
            n_bad++; $display("FAIL wr_busy_cycles @%h: got %0d want %0d", a, low, 4 + lat_of(sel));
        end
        for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            mdl[sel][{a[9:2], kk}] = b[k];
        end
    endtask

    task automatic do_read(input logic [15:0] a, input bit both, input bit toggle);
        int waits, got;
        logic [1:0] kk;
        logic [7:0] e;
        waits = 0; got = 0;
        exp_q.delete();
        @(negedge clock);
        n_cmp++;
        if (rdy_m !== 1'b1) begin n_bad++; $display("FAIL rd_ready_pre: got %b want 1", rdy_m); end
        addr = a; rd = 1'b1; wr = both;
        for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            exp_q.push_back(mdl[sel][{a[9:2], kk}]);
        end
        @(posedge clock); #1 rd = 1'b0; wr = 1'b0;
        if (both) begin tb_drv = 1'b1; tb_dat = 8'hEE; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rv_m) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                got++;
                n_cmp++;
                if (d_m !== e) begin
                    n_bad++; $display("FAIL rd_data @%h byte %0d: got %h want %h", a, got - 1, d_m, e);
                end
            end else if (got == 0) begin
                waits++;
            end
            if (got == 4) break;
            if (toggle) begin
                rd = (got < 3) ? 1'($urandom) : 1'b0;
                wr = (got < 3) ? 1'($urandom) : 1'b0;
            end
            @(posedge clock); #1 tb_drv = 1'b0;
        end
        rd = 1'b0; wr = 1'b0;
        n_cmp++;
        if (waits != lat_of(sel) || got != 4) begin
            n_bad++; $display("FAIL rd_timing @%h: waits=%0d bytes=%0d want %0d/4", a, waits, got, lat_of(sel));
        end
        @(negedge clock);
        n_cmp++;
        if (rv_m !== 1'b0 || rdy_m !== 1'b1) begin
            n_bad++; $display("FAIL rd_end @%h: rvalid=%b ready=%b want 0/1", a, rv_m, rdy_m);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rd = 1'b0; wr = 1'b0; tb_drv = 1'b0; tb_dat = '0; addr = '0; sel = 0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b want 111", {rdy0, rdy1, rdy2}); end
        n_cmp++;
        if ({rv0, rv1, rv2} !== 3'b000) begin n_bad++; $display("FAIL reset_rvalid: got %b want 000", {rv0, rv1, rv2}); end
        @(posedge clock); #1 reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [7:0] b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        sel = 0;
        do_write(16'h0120, b, 1'b0);
        do_read(16'h0123, 1'b0, 1'b0);
    endtask

    task automatic test_rd_wr_both();
        sel = 0;
        do_read(16'h0120, 1'b1, 1'b0);
        do_read(16'h0120, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [7:0] b1 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0] b2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        sel = 0;
        do_write(16'h0040, b1, 1'b0);
        do_write(16'h0040, b2, 1'b1);
        do_read(16'h0040, 1'b0, 1'b0);
    endtask

    task automatic test_alias();
        logic [7:0] b1 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] b2 [4] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        sel = 0;
        do_write(16'h0000, b1, 1'b0);
        do_write(16'h03FC, b2, 1'b0);
        do_read(16'h0401, 1'b0, 1'b0);
        do_read(16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_toggle();
        sel = 0;
        do_read(16'h0120, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        sel = 0;
        do_write(16'h0200, b, 1'b0);
        do_read(16'h0202, 1'b0, 1'b0);
        do_read(16'h0040, 1'b0, 1'b0);
    endtask

    task automatic test_latency();
        logic [7:0] b1 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] b2 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        sel = 1;
        do_write(16'h0100, b1, 1'b0);
        do_read(16'h0102, 1'b0, 1'b0);
        sel = 2;
        do_write(16'h0300, b2, 1'b0);
        do_read(16'h0301, 1'b0, 1'b0);
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rd_wr_both();
        test_abort();
        test_alias();
        test_toggle();
        test_back_to_back();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
